// File: rtl/boot_copier_pkg.sv
// boot_copier_pkg
//   Shared definitions for the boot copier. These include the FSM state
//   encodings, the reset polarity, the ROM bus and address widths, and the
//   zero word used to clear the data latch.
package boot_copier_pkg;

    // FSM state encodings (legacy-compatible constants)
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ROM_REQ  = 3'd1;
    localparam logic [2:0] ST_ROM_WAIT = 3'd2;
    localparam logic [2:0] ST_RAM_WR   = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

    // Reset is active-high
    localparam logic RST_ACTIVE = 1'b1;

    // The ROM decodes addr[11:2], so at most 1024 words can be addressed.
    // The word counter needs one more bit so that it can hold the value 1024.
    localparam int unsigned IDX_W = 10;
    localparam int unsigned CNT_W = 11;
    localparam int unsigned SEL_W = 4;

    localparam logic [SEL_W-1:0] SEL_ALL   = 4'b1111;
    localparam logic [31:0]      ZERO_WORD = 32'h0000_0000;

endpackage

// File: rtl/boot_copier.sv
// boot_copier
//   Bus initiator that copies WORD_NUM consecutive words from the boot ROM
//   into RAM, one word in flight at a time. The CPU is held in reset while
//   busy_o is high.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   start_i         start pulse; honoured only in IDLE or DONE
//   rom_addr_o      ROM byte address, valid while rom_ce_o
//   rom_ce_o        ROM chip enable
//   rom_we_o        tied low (the ROM is read only)
//   rom_data_i      ROM read data
//   rom_ready_i     ROM data valid; registered one cycle after ce
//   ram_addr_o      RAM byte address, valid while ram_ce_o
//   ram_data_o      RAM write data, valid while ram_ce_o
//   ram_ce_o        RAM chip enable
//   ram_we_o        RAM write enable
//   ram_sel_o       byte enables; all set during writes
//   ram_ready_i     RAM write accepted
//   busy_o          copy in progress
//   done_o          copy completed successfully (sticky until next start)
//   err_o           ROM timeout occurred (sticky until next start)
//   word_cnt_o      number of words written so far
module boot_copier
    import boot_copier_pkg::*;
#(
    parameter int unsigned        DATA_W     = 32,
    parameter int unsigned        ADDR_W     = 32,
    parameter int unsigned        WORD_NUM   = 1024,
    parameter logic [ADDR_W-1:0]  ROM_BASE   = '0,
    parameter logic [ADDR_W-1:0]  RAM_BASE   = '0,
    parameter int unsigned        TIMEOUT    = 16,
    parameter bit                 AUTO_START = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    output logic              rom_ce_o,
    output logic              rom_we_o,
    input  logic [DATA_W-1:0] rom_data_i,
    input  logic              rom_ready_i,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_data_o,
    output logic              ram_ce_o,
    output logic              ram_we_o,
    output logic [SEL_W-1:0]  ram_sel_o,
    input  logic              ram_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [CNT_W-1:0]  word_cnt_o
);

    localparam int unsigned       TO_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORD_NUM - 1);

    logic [2:0]        state;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data_q;
    logic [TO_W-1:0]   tcnt;
    logic [CNT_W-1:0]  cnt;
    logic              auto_q;
    logic              done_q;
    logic              err_q;
    logic [ADDR_W-1:0] word_off;

    // auto_q carries the "first cycle after reset" start request. It is
    // loaded by reset and consumed the first time IDLE is left.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ACTIVE) begin
            state  <= ST_IDLE;
            idx    <= '0;
            data_q <= DATA_W'(ZERO_WORD);
            tcnt   <= '0;
            cnt    <= '0;
            auto_q <= AUTO_START;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_i || auto_q) begin
                        state  <= ST_ROM_REQ;
                        idx    <= '0;
                        cnt    <= '0;
                        done_q <= 1'b0;
                        err_q  <= 1'b0;
                        auto_q <= 1'b0;
                    end
                end
                ST_ROM_REQ: begin
                    tcnt  <= '0;
                    state <= ST_ROM_WAIT;
                end
                ST_ROM_WAIT: begin
                    if (rom_ready_i) begin
                        data_q <= rom_data_i;
                        state  <= ST_RAM_WR;
                    end else if (tcnt == TO_LAST) begin
                        err_q <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        tcnt <= tcnt + TO_W'(1);
                    end
                end
                ST_RAM_WR: begin
                    if (ram_ready_i) begin
                        cnt <= cnt + CNT_W'(1);
                        if (idx == LAST_IDX) begin
                            done_q <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            idx   <= idx + IDX_W'(1);
                            state <= ST_ROM_REQ;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Bus outputs are decoded from the state register only, so the ROM and
    // RAM enables are mutually exclusive by construction. Addresses and data
    // are forced to zero when the matching enable is low, so that everything
    // reads zero in reset, IDLE and DONE.
    assign word_off = ADDR_W'({idx, 2'b00});

    assign rom_ce_o   = (state == ST_ROM_REQ) || (state == ST_ROM_WAIT);
    assign rom_we_o   = 1'b0;
    assign rom_addr_o = rom_ce_o ? (ROM_BASE + word_off) : '0;

    assign ram_ce_o   = (state == ST_RAM_WR);
    assign ram_we_o   = ram_ce_o;
    assign ram_sel_o  = ram_ce_o ? SEL_ALL : '0;
    assign ram_addr_o = ram_ce_o ? (RAM_BASE + word_off) : '0;
    assign ram_data_o = ram_ce_o ? data_q : '0;

    assign busy_o     = rom_ce_o || ram_ce_o;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign word_cnt_o = cnt;

endmodule

// File: tb/tb_boot_copier.sv
// tb_boot_copier
//   Scoreboard bench for boot_copier. The stimulus side pushes the expected
//   RAM writes (word index plus ROM contents) into a queue. A negedge monitor
//   pops one entry and compares it on every accepted RAM write. Responders
//   act as a registered ROM with per-word latency and as a RAM with per-word
//   stall counts. The expected completion cycle is derived from those counts.
module tb_boot_copier;

    localparam int unsigned N    = 1024;
    localparam int unsigned TO   = 16;
    localparam logic [31:0] ROMB = 32'h0000_0000;
    localparam logic [31:0] RAMB = 32'h8000_0000;

    logic        clk, rst, start_i;
    logic [31:0] rom_addr_o, rom_data_i, ram_addr_o, ram_data_o;
    logic        rom_ce_o, rom_we_o, rom_ready_i;
    logic        ram_ce_o, ram_we_o, ram_ready_i;
    logic [3:0]  ram_sel_o;
    logic        busy_o, done_o, err_o;
    logic [10:0] word_cnt_o;

    boot_copier #(
        .DATA_W(32), .ADDR_W(32), .WORD_NUM(N), .ROM_BASE(ROMB),
        .RAM_BASE(RAMB), .TIMEOUT(TO), .AUTO_START(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i),
        .rom_addr_o(rom_addr_o), .rom_ce_o(rom_ce_o), .rom_we_o(rom_we_o),
        .rom_data_i(rom_data_i), .rom_ready_i(rom_ready_i),
        .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o), .ram_ce_o(ram_ce_o),
        .ram_we_o(ram_we_o), .ram_sel_o(ram_sel_o), .ram_ready_i(ram_ready_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .word_cnt_o(word_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: event did not occur", name);
    endtask

    typedef struct {
        int unsigned word;
        logic [31:0] data;
    } exp_t;

    exp_t        q[$];
    logic [31:0] rom_mem[1024];
    int unsigned ram_stall[1024];
    int unsigned rom_lat[1024];
    int          dead_word = -1;

    // Expected result of one full copy: word i of ROM lands at RAM word i.
    task automatic push_copy();
        exp_t e;
        for (int unsigned i = 0; i < N; i++) begin
            e.word = i;
            e.data = rom_mem[((ROMB >> 2) + i) % 1024];
            q.push_back(e);
        end
    endtask

    task automatic check_all_zero(input string name);
        chk(name, {rom_addr_o, rom_ce_o, rom_we_o, ram_addr_o, ram_data_o, ram_ce_o,
                   ram_we_o, ram_sel_o, busy_o, done_o, err_o, word_cnt_o}, '0);
    endtask

    // ROM and RAM responders, updated 1 time unit after each rising edge.
    int unsigned rcyc, wcyc;
    logic [9:0]  rw, ww;
    initial begin
        rom_ready_i = 1'b0;
        rom_data_i  = '0;
        ram_ready_i = 1'b0;
        rcyc = 0;
        wcyc = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rom_ce_o) begin
                rw = rom_addr_o[11:2];
                if (rcyc >= 1 + rom_lat[rw] && dead_word != int'(rw)) begin
                    rom_ready_i = 1'b1;
                    rom_data_i  = rom_mem[rw];
                end else begin
                    rom_ready_i = 1'b0;
                    rom_data_i  = $urandom;
                end
                rcyc++;
            end else begin
                rcyc = 0;
                rom_ready_i = 1'b0;
                rom_data_i  = $urandom;
            end
            if (ram_ce_o) begin
                ww = 10'((ram_addr_o - RAMB) >> 2);
                ram_ready_i = (wcyc >= ram_stall[ww]);
                wcyc++;
            end else begin
                wcyc = 0;
                ram_ready_i = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor: bus rules every cycle, scoreboard pop on each accepted write.
    logic        p_ce;
    logic [31:0] p_addr, p_data;
    initial begin
        exp_t e;
        p_ce = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                p_ce = 1'b0;
            end else begin
                chk("ce_exclusive", rom_ce_o & ram_ce_o, 1'b0);
                if (rom_ce_o) begin
                    if (q.size() == 0) fail_now("rom_access_unexpected");
                    else chk("rom_addr", rom_addr_o, ROMB + 32'(4 * q[0].word));
                end
                if (ram_ce_o) begin
                    chk("ram_we_sel", {ram_we_o, ram_sel_o}, 5'b11111);
                    if (p_ce) chk("ram_hold", {ram_addr_o, ram_data_o}, {p_addr, p_data});
                    if (ram_ready_i) begin
                        if (q.size() == 0) begin
                            fail_now("ram_write_unexpected");
                        end else begin
                            e = q.pop_front();
                            chk("ram_addr", ram_addr_o, RAMB + 32'(4 * e.word));
                            chk("ram_data", ram_data_o, e.data);
                        end
                    end
                end
                p_ce   = ram_ce_o && !ram_ready_i;
                p_addr = ram_addr_o;
                p_data = ram_data_o;
            end
        end
    end

    // Run one copy. The caller has released reset or raised start_i at a
    // negedge. Cycle 1 is the first rising edge after that.
    task automatic run_copy(input string tag, input int unsigned exp_cyc,
                            input bit rnd_start, input bit expect_err);
        int unsigned cyc;
        bit fin;
        cyc = 0;
        fin = 1'b0;
        while (!fin) begin
            @(negedge clk);
            cyc++;
            start_i = 1'b0;
            if (cyc == 1) chk({tag, "_first"}, {busy_o, done_o, err_o}, 3'b100);
            if (done_o || err_o) begin
                fin = 1'b1;
            end else if (cyc > exp_cyc + 100) begin
                fail_now({tag, "_end"});
                fin = 1'b1;
            end else if (rnd_start && cyc + 10 < exp_cyc && $urandom_range(0, 40) == 0) begin
                start_i = 1'b1;
            end
        end
        chk({tag, "_cycles"}, cyc, exp_cyc);
        chk({tag, "_flags"}, {busy_o, done_o, err_o}, {1'b0, !expect_err, expect_err});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned exp_cyc;
        int unsigned k;
        rst     = 1'b1;
        start_i = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            rom_mem[i]   = $urandom;
            ram_stall[i] = 0;
            rom_lat[i]   = 0;
        end
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");

        // Auto-start after reset, no stalls: 3 cycles per word plus 1.
        push_copy();
        rst = 1'b0;
        run_copy("copy_auto", 3 * N + 1, 1'b0, 1'b0);
        chk("copy_auto_cnt", word_cnt_o, 11'd1024);
        chk("copy_auto_q", q.size(), 0);

        // Restart from DONE with new data, random ROM and RAM stalls and
        // start pulses while busy. Word 2 gets a fixed 5-cycle RAM stall.
        exp_cyc = 3 * N + 1;
        for (int i = 0; i < 1024; i++) begin
            rom_mem[i]   = $urandom;
            ram_stall[i] = $urandom_range(0, 3);
            rom_lat[i]   = $urandom_range(0, 2);
        end
        ram_stall[2] = 5;
        for (int i = 0; i < 1024; i++) exp_cyc += ram_stall[i] + rom_lat[i];
        push_copy();
        @(negedge clk);
        start_i = 1'b1;
        run_copy("copy_stall", exp_cyc, 1'b1, 1'b0);
        chk("copy_stall_cnt", word_cnt_o, 11'd1024);
        chk("copy_stall_q", q.size(), 0);

        // ROM never answers for word 1: 16 wait cycles, then error.
        for (int i = 0; i < 1024; i++) begin
            ram_stall[i] = 0;
            rom_lat[i]   = 0;
        end
        dead_word = 1;
        k = 1;
        for (int unsigned i = 0; i <= k; i++) q.push_back('{word: i, data: rom_mem[i]});
        @(negedge clk);
        start_i = 1'b1;
        run_copy("timeout", 1 + 3 * k + 1 + TO, 1'b0, 1'b1);
        chk("timeout_cnt", word_cnt_o, 11'(k));
        chk("timeout_q", q.size(), 1);
        q.delete();
        dead_word = -1;

        // Asynchronous reset during the RAM write of word 2, then auto restart.
        push_copy();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        k = 0;
        while (k < 200 && !(ram_ce_o && ram_addr_o == RAMB + 32'd8)) begin
            @(posedge clk);
            #2;
            k++;
        end
        if (k >= 200) fail_now("reach_word2_write");
        rst = 1'b1;
        #1;
        check_all_zero("reset_midcopy");
        chk("reset_midcopy_q", q.size(), N - 2);
        q.delete();
        push_copy();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_copy("copy_restart", 3 * N + 1, 1'b0, 1'b0);
        chk("copy_restart_cnt", word_cnt_o, 11'd1024);
        chk("copy_restart_q", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
